// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, branch redirect
// and the decode-side instruction handoff.
// MISALIGN_TRAP_EN adds the misaligned_fetch flag to the bundle.
interface instruction_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instruction_memory;
  logic [31:0] program_counter;
  logic        fetch_valid;
  logic        fetch_ready;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned_fetch;
`endif

  // Fetch unit side
  modport master (
    output imem_req_valid, imem_req_addr, instruction_memory, program_counter, fetch_valid,
`ifdef MISALIGN_TRAP_EN
    output misaligned_fetch,
`endif
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_target,
    input  fetch_ready
  );

  // Memory / decode / branch-unit side
  modport slave (
    input  imem_req_valid, imem_req_addr, instruction_memory, program_counter, fetch_valid,
`ifdef MISALIGN_TRAP_EN
    input  misaligned_fetch,
`endif
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_target,
    output fetch_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues word fetches under a credit
// limit of FIFO_DEPTH (in flight + buffered), pairs returned words with their
// PC and hands them to decode in order. A redirect flushes the buffer and
// marks every still-outstanding response to be discarded on arrival.
// Optional feature macro: MISALIGN_TRAP_EN (trap on misaligned redirect
// target instead of silently aligning it).
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  instruction_fetch_unit_if.master bus
);

  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam int            CW      = AW + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   pc_q;
  logic [CW-1:0] outstanding_q;
  logic [CW-1:0] drop_q;
  logic [CW-1:0] occ_q;
  logic [AW-1:0] pcq_wr_q;
  logic [AW-1:0] pcq_rd_q;
  logic [AW-1:0] fifo_wr_q;
  logic [AW-1:0] fifo_rd_q;
  logic [31:0]   pcq_mem   [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [31:0]   fifo_word [FIFO_DEPTH];

  logic          req_fire;
  logic          resp_drop;
  logic          resp_push;
  logic          pop;
  logic          issue_ok;
  logic [CW-1:0] outstanding_nxt;
  logic [CW:0]   credit_used;
  logic [31:0]   target;

  assign credit_used     = {1'b0, outstanding_q} + {1'b0, occ_q};
  assign req_fire        = bus.imem_req_valid && bus.imem_req_ready;
  assign resp_drop       = bus.imem_resp_valid && (drop_q != '0);
  assign resp_push       = bus.imem_resp_valid && (drop_q == '0);
  assign pop             = bus.fetch_valid && bus.fetch_ready;
  assign outstanding_nxt = outstanding_q + {{(CW-1){1'b0}}, req_fire}
                                         - {{(CW-1){1'b0}}, bus.imem_resp_valid};

`ifdef MISALIGN_TRAP_EN
  logic trap_q;

  assign target               = bus.redirect_target;
  assign issue_ok             = !trap_q;
  assign bus.misaligned_fetch = trap_q;

  // Trap flag: set by a misaligned redirect, cleared by an aligned one
  always_ff @(posedge clk) begin
    if (rst) begin
      trap_q <= 1'b0;
    end else if (bus.redirect_valid) begin
      trap_q <= (bus.redirect_target[1:0] != 2'b00);
    end
  end
`else
  assign target   = bus.redirect_target & 32'hFFFF_FFFC;
  assign issue_ok = 1'b1;
`endif

  assign bus.imem_req_valid     = !rst && issue_ok && (credit_used < DEPTH_C);
  assign bus.imem_req_addr      = pc_q;
  assign bus.fetch_valid        = (occ_q != '0);
  assign bus.instruction_memory = bus.fetch_valid ? fifo_word[fifo_rd_q] : '0;
  assign bus.program_counter    = bus.fetch_valid ? fifo_pc[fifo_rd_q]   : '0;

  // Control: PC, credit counters, drop count and queue pointers; redirect wins
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      occ_q         <= '0;
      pcq_wr_q      <= '0;
      pcq_rd_q      <= '0;
      fifo_wr_q     <= '0;
      fifo_rd_q     <= '0;
    end else begin
      outstanding_q <= outstanding_nxt;
      if (bus.redirect_valid) begin
        // Everything still in flight after this edge belongs to the old path
        pc_q      <= target;
        drop_q    <= outstanding_nxt;
        occ_q     <= '0;
        pcq_wr_q  <= '0;
        pcq_rd_q  <= '0;
        fifo_wr_q <= '0;
        fifo_rd_q <= '0;
      end else begin
        if (req_fire) begin
          pc_q     <= pc_q + 32'd4;
          pcq_wr_q <= pcq_wr_q + 1'b1;
        end
        if (resp_drop) begin
          drop_q <= drop_q - 1'b1;
        end
        if (resp_push) begin
          pcq_rd_q  <= pcq_rd_q + 1'b1;
          fifo_wr_q <= fifo_wr_q + 1'b1;
        end
        if (pop) begin
          fifo_rd_q <= fifo_rd_q + 1'b1;
        end
        occ_q <= occ_q + {{(CW-1){1'b0}}, resp_push} - {{(CW-1){1'b0}}, pop};
      end
    end
  end

  // Storage: PC of each kept request, then the {PC, word} pair on response
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pcq_mem[pcq_wr_q] <= pc_q;
    end
    if (resp_push) begin
      fifo_pc[fifo_wr_q]   <= pcq_mem[pcq_rd_q];
      fifo_word[fifo_wr_q] <= bus.imem_resp_data;
    end
  end

endmodule
